// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing one memory bus between fetch and data ports
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_err,
    input  logic                d_req,
    input  logic                d_wen,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                bus_ren,
    output logic                bus_wen,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_ready
);
    localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          last_d, sel_d, pick_d, req_any, expired, done;

    assign req_any = if_req | d_req;
    assign pick_d  = d_req & (~if_req | ~last_d);
    assign expired = (TIMEOUT != 0) && (cnt == CW'(TLAST));
    assign done    = bus_ready | expired;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state selection
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = req_any ? BUSY : IDLE;
            BUSY:    state_nx = done ? RESP : BUSY;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // grant latching, bus strobes, watchdog and registered responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d    <= 1'b0;
            sel_d     <= 1'b0;
            cnt       <= '0;
            bus_ren   <= 1'b0;
            bus_wen   <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wstrb <= '0;
            if_ack    <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: if (req_any) begin
                    sel_d     <= pick_d;
                    last_d    <= pick_d;
                    cnt       <= '0;
                    bus_addr  <= pick_d ? d_addr : if_addr;
                    bus_wdata <= pick_d ? d_wdata : '0;
                    bus_wstrb <= pick_d ? d_wstrb : '0;
                    bus_ren   <= ~(pick_d & d_wen);
                    bus_wen   <= pick_d & d_wen;
                end
                BUSY: if (done) begin
                    bus_ren <= 1'b0;
                    bus_wen <= 1'b0;
                    cnt     <= '0;
                    if (sel_d) begin
                        d_ack   <= 1'b1;
                        d_err   <= ~bus_ready;
                        d_rdata <= (bus_ready & ~bus_wen) ? bus_rdata : '0;
                    end else begin
                        if_ack   <= 1'b1;
                        if_err   <= ~bus_ready;
                        if_rdata <= bus_ready ? bus_rdata : '0;
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end
                RESP: begin
                    if_ack <= 1'b0;
                    if_err <= 1'b0;
                    d_ack  <= 1'b0;
                    d_err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench for the fetch/data bus arbiter
module tb_mem_bus_arbiter;
    localparam logic [31:0] NOISE = 32'hBAD0_0000;

    typedef struct {
        logic        d, ren, wen;
        logic [31:0] addr, bwdata;
        logic [3:0]  bwstrb;
        int          lat;
        logic [31:0] sdata;
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } txn_t;

    logic        clk, rst;
    logic        if_req, if_ack, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_wen, d_ack, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        bus_ren, bus_wen, bus_ready;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;

    logic        z_if_req, z_if_ack, z_if_err;
    logic [31:0] z_if_addr, z_if_rdata;
    logic        z_d_req, z_d_wen, z_d_ack, z_d_err;
    logic [31:0] z_d_addr, z_d_wdata, z_d_rdata;
    logic [3:0]  z_d_wstrb;
    logic        z_bus_ren, z_bus_wen, z_bus_ready;
    logic [31:0] z_bus_addr, z_bus_wdata, z_bus_rdata;
    logic [3:0]  z_bus_wstrb;

    txn_t bq[$];
    txn_t aq[$];
    txn_t cur, e;
    logic cur_v, p_if, p_d;
    int   bcnt;
    int   total, bad;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) u_dut_z (
        .clk(clk), .rst(rst),
        .if_req(z_if_req), .if_addr(z_if_addr), .if_ack(z_if_ack), .if_rdata(z_if_rdata), .if_err(z_if_err),
        .d_req(z_d_req), .d_wen(z_d_wen), .d_addr(z_d_addr), .d_wdata(z_d_wdata), .d_wstrb(z_d_wstrb),
        .d_ack(z_d_ack), .d_rdata(z_d_rdata), .d_err(z_d_err),
        .bus_ren(z_bus_ren), .bus_wen(z_bus_wen), .bus_addr(z_bus_addr), .bus_wdata(z_bus_wdata),
        .bus_wstrb(z_bus_wstrb), .bus_rdata(z_bus_rdata), .bus_ready(z_bus_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input logic d, input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int lat, input logic [31:0] sdata, input int cyc,
                        input logic [31:0] rd, input logic err, input bit ack);
        txn_t t;
        t.d      = d;
        t.ren    = !(d && wen);
        t.wen    = d && wen;
        t.addr   = addr;
        t.bwdata = d ? wdata : 32'h0;
        t.bwstrb = d ? wstrb : 4'h0;
        t.lat    = lat;
        t.sdata  = sdata;
        t.cyc    = cyc;
        t.rdata  = rd;
        t.err    = err;
        bq.push_back(t);
        if (ack) aq.push_back(t);
    endtask

    task automatic wait_ack(input logic d, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(d ? d_ack : if_ack) && n < 400);
        chk("ack_seen", d ? d_ack : if_ack, 1);
    endtask

    task automatic run_txn(input logic d, input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int lat, input logic [31:0] sdata, input int cyc,
                           input logic [31:0] rd, input logic err, input int elat);
        int n;
        push(d, wen, addr, wdata, wstrb, lat, sdata, cyc, rd, err, 1'b1);
        @(negedge clk);
        if (d) begin
            d_req = 1'b1; d_wen = wen; d_addr = addr; d_wdata = wdata; d_wstrb = wstrb;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        wait_ack(d, n);
        if (d) d_req = 1'b0;
        else   if_req = 1'b0;
        chk("latency", n, elat);
    endtask

    // bus slave: serves each access from the expected queue and checks the strobes/payload
    always @(negedge clk) begin
        if (rst) begin
            cur_v = 1'b0;
            bcnt = 0;
            bus_ready = 1'b1;
            bus_rdata = NOISE;
        end else if (bus_ren | bus_wen) begin
            if (!cur_v) begin
                if (bq.size() == 0) chk("spurious_bus", bus_ren | bus_wen, 0);
                else begin
                    cur = bq.pop_front();
                    cur_v = 1'b1;
                    bcnt = 0;
                end
            end
            if (cur_v) begin
                bcnt++;
                chk("bus_ren", bus_ren, cur.ren);
                chk("bus_wen", bus_wen, cur.wen);
                chk("bus_addr", bus_addr, cur.addr);
                chk("bus_wdata", bus_wdata, cur.bwdata);
                chk("bus_wstrb", bus_wstrb, cur.bwstrb);
                bus_ready = (cur.lat != 0 && bcnt == cur.lat);
                bus_rdata = bus_ready ? cur.sdata : NOISE;
            end
        end else begin
            if (cur_v) begin
                chk("busy_cycles", bcnt, cur.cyc);
                cur_v = 1'b0;
            end
            bus_ready = 1'b1;
            bus_rdata = NOISE;
        end
        chk("strobe_overlap", bus_ren & bus_wen, 0);
    end

    // response monitor: each ack pops the oldest expected response
    always @(negedge clk) begin
        if (rst) begin
            p_if = 1'b0;
            p_d = 1'b0;
        end else begin
            if (p_if) chk("if_ack_pulse", if_ack, 0);
            if (p_d)  chk("d_ack_pulse", d_ack, 0);
            if (if_ack | d_ack) begin
                if (aq.size() == 0) chk("spurious_ack", if_ack | d_ack, 0);
                else begin
                    e = aq.pop_front();
                    chk("ack_port_d", d_ack, e.d);
                    chk("ack_port_if", if_ack, !e.d);
                    chk("rdata", e.d ? d_rdata : if_rdata, e.rdata);
                    chk("err", e.d ? d_err : if_err, e.err);
                end
            end
            p_if = if_ack;
            p_d = d_ack;
        end
    end

    initial begin
        int n, k;
        logic seen;
        total = 0; bad = 0;
        rst = 1'b1;
        if_req = 0; if_addr = 0; d_req = 0; d_wen = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
        z_if_req = 0; z_if_addr = 0; z_d_req = 0; z_d_wen = 0; z_d_addr = 0; z_d_wdata = 0; z_d_wstrb = 0;
        z_bus_ready = 0; z_bus_rdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_if_ack", if_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_bus_ren", bus_ren, 0);
        chk("rst_bus_wen", bus_wen, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_bus_wstrb", bus_wstrb, 0);
        rst = 1'b0;

        run_txn(1'b0, 1'b0, 32'h0040_0000, 32'h0, 4'h0, 1, 32'h2408_0001, 1, 32'h2408_0001, 1'b0, 2);
        run_txn(1'b1, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'h3, 4, 32'h1234_5678, 4, 32'h0, 1'b0, 5);

        push(1'b1, 1'b0, 32'h1001_0010, 32'h0, 4'hF, 0, 32'h0, 8, 32'h0, 1'b1, 1'b1);
        push(1'b0, 1'b0, 32'h0040_0004, 32'h0, 4'h0, 1, 32'h8C09_0000, 1, 32'h8C09_0000, 1'b0, 1'b1);
        @(negedge clk);
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h1001_0010; d_wdata = 32'h0; d_wstrb = 4'hF;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0040_0004;
        wait_ack(1'b1, n);
        d_req = 1'b0;
        chk("timeout_lat", n, 8);
        wait_ack(1'b0, n);
        if_req = 1'b0;
        chk("after_timeout_lat", n, 3);

        run_txn(1'b1, 1'b0, 32'h1001_0020, 32'h0, 4'hF, 8, 32'hCAFE_F00D, 8, 32'hCAFE_F00D, 1'b0, 9);

        push(1'b1, 1'b1, 32'h1001_0030, 32'h5555_AAAA, 4'hC, 0, 32'h0, 0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h1001_0030; d_wdata = 32'h5555_AAAA; d_wstrb = 4'hC;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_wen", bus_wen, 0);
        chk("rst_async_ren", bus_ren, 0);
        chk("rst_async_ack", d_ack, 0);
        @(negedge clk);
        d_req = 1'b0;
        d_wen = 1'b0; d_addr = 32'h1001_0100; d_wdata = 32'h0; d_wstrb = 4'hF;
        if_addr = 32'h0040_0100;
        push(1'b1, 1'b0, 32'h1001_0100, 32'h0, 4'hF, 2, 32'h1111_0001, 2, 32'h1111_0001, 1'b0, 1'b1);
        push(1'b0, 1'b0, 32'h0040_0100, 32'h0, 4'h0, 1, 32'h2222_0001, 1, 32'h2222_0001, 1'b0, 1'b1);
        push(1'b1, 1'b0, 32'h1001_0100, 32'h0, 4'hF, 3, 32'h1111_0002, 3, 32'h1111_0002, 1'b0, 1'b1);
        push(1'b0, 1'b0, 32'h0040_0100, 32'h0, 4'h0, 1, 32'h2222_0002, 1, 32'h2222_0002, 1'b0, 1'b1);
        if_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0; k = 0;
        while (k < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (if_ack | d_ack) k++;
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("contention_acks", k, 4);
        repeat (3) @(negedge clk);
        chk("queue_drained", aq.size() + bq.size(), 0);

        z_d_req = 1'b1; z_d_wen = 1'b0; z_d_addr = 32'h1001_0200; z_d_wstrb = 4'hF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!z_bus_ren && n < 10);
        chk("z_ren_start", z_bus_ren, 1);
        seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            seen = seen | z_d_ack | z_if_ack;
        end
        chk("z_no_ack_stall", seen, 0);
        chk("z_ren_held", z_bus_ren, 1);
        chk("z_wen_low", z_bus_wen, 0);
        chk("z_addr_held", z_bus_addr, 32'h1001_0200);
        chk("z_wdata", z_bus_wdata, 32'h0);
        chk("z_wstrb", z_bus_wstrb, 4'hF);
        z_bus_ready = 1'b1; z_bus_rdata = 32'h0BAD_CAFE;
        @(negedge clk);
        z_bus_ready = 1'b0; z_bus_rdata = 32'h0;
        chk("z_ack", z_d_ack, 1);
        chk("z_err", z_d_err, 0);
        chk("z_rdata", z_d_rdata, 32'h0BAD_CAFE);
        chk("z_if_side", {z_if_ack, z_if_err, z_if_rdata[29:0]}, 0);
        z_d_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single common memory/device bus between the instruction-fetch port and the data port of the CPU.
- Sits between the CPU's memory ports and the address router / data memory.
- Serialises requests, arbitrates round-robin, and holds bus strobes until the slave signals ready.
- Converts a stalled slave into an error response via a watchdog timeout.

Parameters:
- ADDR_W, 32, address width of both ports and the bus.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- TIMEOUT, 255, maximum BUSY cycles waiting for bus_ready before an error response; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, level, held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle response pulse.
- if_rdata  out  DATA_W  fetch data, valid with if_ack.
- if_err  out  1  timeout error, valid with if_ack.
- d_req  in  1  data request, level, held until d_ack.
- d_wen  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_wstrb  in  DATA_W/8  byte strobes.
- d_ack  out  1  one-cycle response pulse.
- d_rdata  out  DATA_W  read data, valid with d_ack.
- d_err  out  1  timeout error, valid with d_ack.
- bus_ren  out  1  bus read strobe.
- bus_wen  out  1  bus write strobe.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_wstrb  out  DATA_W/8  bus byte strobes.
- bus_rdata  in  DATA_W  bus read data.
- bus_ready  in  1  slave completes the current access this cycle.

Behaviour:
- One clock domain. Reset is asynchronous, active-high.
- During reset, and for every output:
  - all outputs 0;
  - state = IDLE;
  - last_grant = IF;
  - timeout counter = 0.
- State machine:
  - IDLE: sample if_req/d_req.
    - Only one asserted -> grant it.
    - Both asserted -> grant the port that was not last_grant. After reset, data wins the first tie.
    - On grant: latch addr/wdata/wstrb/wen into the bus output registers, update last_grant, go to BUSY.
    - For a fetch grant: bus_wdata = 0, bus_wstrb = 0, read only.
  - BUSY:
    - bus_ren = ~wen_latched; bus_wen = wen_latched. Both are registered and stable for the whole state.
    - bus_addr/wdata/wstrb held constant.
    - Counter increments each BUSY cycle.
    - bus_ready = 1: capture bus_rdata (reads only) and go to RESP with err = 0.
    - No ready for TIMEOUT consecutive BUSY cycles (TIMEOUT != 0): go to RESP with err = 1, rdata = 0.
    - Ready in the final allowed cycle wins over the timeout.
  - RESP:
    - Pulse x_ack = 1 for the granted port only; x_err as determined in BUSY.
    - bus_ren/bus_wen = 0; counter cleared.
    - Go to IDLE.
- Ack timing: ack is registered. Minimum latency is request sampled in IDLE at cycle 0, BUSY at cycle 1 with ready, ack at cycle 2.
- Throughput: at most one transaction per 3 cycles.
- Requester rule: a requester must deassert req, or present a new transaction, in the cycle after its ack. A req seen in IDLE is always a new transaction.
- Read data: x_rdata holds its value until the next ack on that port. Write acks set d_rdata = 0.
- bus_ready outside BUSY is ignored.
- Strobes: bus_ren and bus_wen are never both 1, and both are 0 outside BUSY.
- A request that appears during BUSY/RESP waits in IDLE arbitration. Requesters must not change addr/data while req is high and unacked.
- Reset mid-transaction: abandon the transaction immediately (async). No ack or err is issued for it. The CPU re-issues after reset.

Test Plan:
1. Single read: if_req = 1, if_addr = 0x00400000; bus_ready = 1 in the first BUSY cycle with bus_rdata = 0x24080001 -> bus_ren high for exactly 1 cycle with bus_addr = 0x00400000; if_ack at cycle 2 with if_rdata = 0x24080001, if_err = 0.
2. Write with wait states: d_req = 1, d_wen = 1, d_addr = 0x10010004, d_wdata = 0xDEADBEEF, d_wstrb = 0x3; bus_ready after 4 BUSY cycles -> bus_wen held 4 cycles with constant addr/data/strb; d_ack once; d_rdata = 0; bus_ren = 0 throughout.
3. Contention: if_req and d_req both held from reset -> data granted first, then fetch, then data alternating; each ack exactly one cycle; no strobe overlap.
4. Timeout: TIMEOUT = 8, d_req read, bus_ready never asserted -> bus_ren high exactly 8 cycles; d_ack = 1 with d_err = 1 and d_rdata = 0; arbiter then serves a pending if_req normally.
5. Boundary: TIMEOUT = 8, ready asserted in BUSY cycle 8 -> normal ack with err = 0. TIMEOUT = 0 with 300-cycle stall -> no error, ack after ready.
6. Reset mid-BUSY: assert rst during a write -> bus_wen drops asynchronously, no ack is issued; after release the first tie again goes to data.
